// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one external combinational ALU between two requesters.
//   req 0 : main execute path
//   req 1 : address-generation / CSR helper
// A request is granted in IDLE and its op/operands are latched. The ALU sees
// them for one EXEC cycle, and the result and flags are captured at the end of
// that cycle. They are then returned to the owning requester in RESP until
// that requester accepts them.
// Sequence: IDLE -> EXEC -> RESP -> IDLE. A response is valid two cycles
// after the accept edge, so at most one operation completes every three cycles.
//
// Ports
//   clk                     clock, rising edge
//   arstn                   synchronous active-low reset
//   i_req_valid_0/1         request valid
//   o_req_ready_0/1         request accepted when valid & ready
//   i_req_op_0/1            ALU operation code
//   i_req_src1_0/1          operand 1
//   i_req_src2_0/1          operand 2
//   o_rsp_valid_0/1         response valid (owner only)
//   i_rsp_ready_0/1         response accepted by requester
//   o_rsp_result            captured ALU result (shared)
//   o_rsp_flags             captured {overflow, zero, negative, carry}
//   o_alu_control           to ALU operation select
//   o_alu_src_1/2           to ALU operands
//   i_alu_result            from ALU result
//   i_alu_overflow/zero/negative/carry   ALU flags
//   o_busy                  high whenever not IDLE
//
// Build option
//   ALU_ARB_FIXED_PRIO_EN   when defined, requester 0 always wins contention
//                           and no round-robin pointer exists. When undefined
//                           (the default), a round-robin pointer alternates
//                           the winner.
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int CONTROL_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     arstn,
  input  logic                     i_req_valid_0,
  input  logic                     i_req_valid_1,
  output logic                     o_req_ready_0,
  output logic                     o_req_ready_1,
  input  logic [CONTROL_WIDTH-1:0] i_req_op_0,
  input  logic [CONTROL_WIDTH-1:0] i_req_op_1,
  input  logic [DATA_WIDTH-1:0]    i_req_src1_0,
  input  logic [DATA_WIDTH-1:0]    i_req_src1_1,
  input  logic [DATA_WIDTH-1:0]    i_req_src2_0,
  input  logic [DATA_WIDTH-1:0]    i_req_src2_1,
  output logic                     o_rsp_valid_0,
  output logic                     o_rsp_valid_1,
  input  logic                     i_rsp_ready_0,
  input  logic                     i_rsp_ready_1,
  output logic [DATA_WIDTH-1:0]    o_rsp_result,
  output logic [3:0]               o_rsp_flags,
  output logic [CONTROL_WIDTH-1:0] o_alu_control,
  output logic [DATA_WIDTH-1:0]    o_alu_src_1,
  output logic [DATA_WIDTH-1:0]    o_alu_src_2,
  input  logic [DATA_WIDTH-1:0]    i_alu_result,
  input  logic                     i_alu_overflow,
  input  logic                     i_alu_zero,
  input  logic                     i_alu_negative,
  input  logic                     i_alu_carry,
  output logic                     o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [CONTROL_WIDTH-1:0] op_q, op_d;
  logic [DATA_WIDTH-1:0]    src1_q, src1_d;
  logic [DATA_WIDTH-1:0]    src2_q, src2_d;
  logic [DATA_WIDTH-1:0]    result_q, result_d;
  logic [3:0]               flags_q, flags_d;
  logic                     owner_q, owner_d;

  logic [1:0] req_valid;
  logic [1:0] rsp_ready;
  logic [1:0] rsp_valid;
  logic       prio_sel;    // winner when both requesters are valid
  logic       grant_sel;   // index of the requester granted this cycle
  logic       accept;      // a request handshake happens this cycle
  logic       rsp_fire;    // the owner accepts the response this cycle

  assign req_valid = {i_req_valid_1, i_req_valid_0};
  assign rsp_ready = {i_rsp_ready_1, i_rsp_ready_0};

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign prio_sel = 1'b0;
`else
  logic rr_ptr_q, rr_ptr_d;
  assign prio_sel = rr_ptr_q;
`endif

  // The grant is combinational in IDLE. A single valid requester always wins.
  // Readies are gated by reset so nothing handshakes while reset is held.
  assign grant_sel = (&req_valid) ? prio_sel : req_valid[1];
  assign accept    = arstn && (state_q == IDLE) && (|req_valid);
  assign rsp_fire  = (state_q == RESP) && rsp_ready[owner_q];

  assign o_req_ready_0 = accept && !grant_sel;
  assign o_req_ready_1 = accept &&  grant_sel;

  // A response is shown only to its owner and is suppressed during reset,
  // so an operation interrupted by reset never produces a response.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rsp_valid
    assign rsp_valid[gi] = arstn && (state_q == RESP) && (owner_q == 1'(gi));
  end

  assign o_rsp_valid_0 = rsp_valid[0];
  assign o_rsp_valid_1 = rsp_valid[1];
  assign o_rsp_result  = result_q;
  assign o_rsp_flags   = flags_q;

  // The ALU is always driven from the latched registers. Its inputs stay
  // stable across EXEC and RESP.
  assign o_alu_control = op_q;
  assign o_alu_src_1   = src1_q;
  assign o_alu_src_2   = src2_q;
  assign o_busy        = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    result_d = result_q;
    flags_d  = flags_q;
    owner_d  = owner_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    rr_ptr_d = rr_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = grant_sel ? i_req_op_1   : i_req_op_0;
          src1_d  = grant_sel ? i_req_src1_1 : i_req_src1_0;
          src2_d  = grant_sel ? i_req_src2_1 : i_req_src2_0;
          owner_d = grant_sel;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // The ALU outputs are sampled in this cycle only.
        result_d = i_alu_result;
        flags_d  = {i_alu_overflow, i_alu_zero, i_alu_negative, i_alu_carry};
        state_d  = RESP;
      end
      RESP: begin
        if (rsp_fire) begin
          state_d  = IDLE;
`ifndef ALU_ARB_FIXED_PRIO_EN
          // The requester just served gets lower priority next time.
          rr_ptr_d = ~owner_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arstn) begin
      state_q  <= IDLE;
      op_q     <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      result_q <= '0;
      flags_q  <= '0;
      owner_q  <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      rr_ptr_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      owner_q  <= owner_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: table-driven single transactions, hand-written
// contention / backpressure / reset sequences, then randomized traffic checked
// against a transaction-level reference model (timestamps, not states).
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic [1:0]  v = 2'b00;
  logic [1:0]  rr = 2'b00;
  logic [3:0]  op [2];
  logic [31:0] a [2];
  logic [31:0] b [2];
  logic [1:0]  rdy_o;
  logic [1:0]  rv_o;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic [3:0]  alu_ctl;
  logic [31:0] alu_s1, alu_s2;
  logic [35:0] alu_out;
  logic        busy;
  logic        alu_clean = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_WIDTH(32), .CONTROL_WIDTH(4)) dut (
    .clk           (clk),
    .arstn         (arstn),
    .i_req_valid_0 (v[0]),
    .i_req_valid_1 (v[1]),
    .o_req_ready_0 (rdy_o[0]),
    .o_req_ready_1 (rdy_o[1]),
    .i_req_op_0    (op[0]),
    .i_req_op_1    (op[1]),
    .i_req_src1_0  (a[0]),
    .i_req_src1_1  (a[1]),
    .i_req_src2_0  (b[0]),
    .i_req_src2_1  (b[1]),
    .o_rsp_valid_0 (rv_o[0]),
    .o_rsp_valid_1 (rv_o[1]),
    .i_rsp_ready_0 (rr[0]),
    .i_rsp_ready_1 (rr[1]),
    .o_rsp_result  (rsp_result),
    .o_rsp_flags   (rsp_flags),
    .o_alu_control (alu_ctl),
    .o_alu_src_1   (alu_s1),
    .o_alu_src_2   (alu_s2),
    .i_alu_result  (alu_out[31:0]),
    .i_alu_overflow(alu_out[35]),
    .i_alu_zero    (alu_out[34]),
    .i_alu_negative(alu_out[33]),
    .i_alu_carry   (alu_out[32]),
    .o_busy        (busy)
  );

  // Reference ALU: returns {overflow, zero, negative, carry, result}.
  // Codes: 0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 SLL 6 SLT 7 SLTU 8 SRL 9 SRA.
  // Codes 10..15 give result 0 with every flag 0.
  function automatic logic [35:0] alu_ref(input logic [3:0] f_op,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
    logic [32:0] s;
    logic [31:0] r;
    logic        ov, c;
    ov = 1'b0;
    c  = 1'b0;
    case (f_op)
      4'd0: begin
        s  = {1'b0, x} + {1'b0, y};
        r  = s[31:0];
        c  = s[32];
        ov = (x[31] == y[31]) && (r[31] != x[31]);
      end
      4'd1: begin
        r  = x - y;
        c  = (x < y);
        ov = (x[31] != y[31]) && (r[31] != x[31]);
      end
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      4'd5: r = x << y[4:0];
      4'd6: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd7: r = (x < y) ? 32'd1 : 32'd0;
      4'd8: r = x >> y[4:0];
      4'd9: r = $unsigned($signed(x) >>> y[4:0]);
      default: return 36'd0;
    endcase
    return {ov, (r == 32'd0), r[31], c, r};
  endfunction

  // The external ALU model. Outside the one cycle where the arbiter should be
  // sampling it, it returns inverted data so that any mistimed capture shows.
  always_comb begin
    alu_out = alu_ref(alu_ctl, alu_s1, alu_s2);
    if (!alu_clean) alu_out = ~alu_out;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  int          cyc = 0;
  logic        m_busy = 1'b0;   // a transaction is held
  int          m_acc = 0;       // cycle number of its accept edge
  logic        m_owner = 1'b0;
  logic        m_pref = 1'b0;   // winner under contention
  logic [35:0] m_exp = '0;
  logic [3:0]  m_op = '0;
  logic [31:0] m_a = '0, m_b = '0;
  logic [1:0]  last_er = 2'b00; // model's grants in the last tick
  int          grants[$];       // DUT grants observed (for directed checks)

  // One clock cycle: check outputs against the model, then advance the model.
  task automatic tick();
    logic       in_resp;
    logic [1:0] er, erv;
    in_resp   = m_busy && (cyc >= m_acc + 2);
    alu_clean = m_busy && (cyc == m_acc + 1);
    er[0]  = arstn && !m_busy && v[0] && (!v[1] || !m_pref);
    er[1]  = arstn && !m_busy && v[1] && (!v[0] ||  m_pref);
    erv[0] = arstn && in_resp && !m_owner;
    erv[1] = arstn && in_resp &&  m_owner;
    #1;
    chk("req_ready_0", 64'(rdy_o[0]), 64'(er[0]));
    chk("req_ready_1", 64'(rdy_o[1]), 64'(er[1]));
    chk("rsp_valid_0", 64'(rv_o[0]), 64'(erv[0]));
    chk("rsp_valid_1", 64'(rv_o[1]), 64'(erv[1]));
    if (arstn) chk("busy", 64'(busy), 64'(m_busy));
    if (|erv) begin
      chk("rsp_result", 64'(rsp_result), 64'(m_exp[31:0]));
      chk("rsp_flags", 64'(rsp_flags), 64'(m_exp[35:32]));
    end
    if (rdy_o[0] && v[0]) grants.push_back(0);
    if (rdy_o[1] && v[1]) grants.push_back(1);
    last_er = er;
    @(posedge clk);
    if (!arstn) begin
      m_busy = 1'b0;
      m_pref = 1'b0;
    end else if (|er) begin
      m_busy  = 1'b1;
      m_acc   = cyc;
      m_owner = er[1];
      m_op    = op[er[1]];
      m_a     = a[er[1]];
      m_b     = b[er[1]];
      m_exp   = alu_ref(m_op, m_a, m_b);
    end else if (in_resp && rr[m_owner]) begin
      m_busy = 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      m_pref = !m_owner;
`endif
      $display("txn req%0d op=%0d a=%h b=%h -> result=%h flags=%b",
               m_owner, m_op, m_a, m_b, m_exp[31:0], m_exp[35:32]);
    end
    cyc++;
    @(negedge clk);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flags;   // {ov, z, n, c}
  } vec_t;

  vec_t vecs[13];

  task automatic do_reset(input int n);
    arstn = 1'b0;
    for (int i = 0; i < n; i++) tick();
    arstn = 1'b1;
  endtask

  task automatic run_single(input int r, input vec_t t, input int idx);
    v = '0;
    rr = 2'b11;
    v[r] = 1'b1;
    op[r] = t.op;
    a[r] = t.a;
    b[r] = t.b;
    tick();                       // accept
    v[r] = 1'b0;
    tick();                       // EXEC
    #1;
    chk($sformatf("vec%0d_rsp_valid", idx), 64'(rv_o[r]), 64'd1);
    chk($sformatf("vec%0d_result", idx), 64'(rsp_result), 64'(t.res));
    chk($sformatf("vec%0d_flags", idx), 64'(rsp_flags), 64'(t.flags));
    chk($sformatf("vec%0d_alu_ctrl", idx), 64'(alu_ctl), 64'(t.op));
    tick();                       // response handshake
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(3))
      0: return 32'h7FFFFFFF;
      1: return 32'h80000000;
      2: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [1:0] pend;
    int exp_g;
    op[0] = '0; op[1] = '0;
    a[0] = '0; a[1] = '0;
    b[0] = '0; b[1] = '0;

    vecs[0]  = '{4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1010};
    vecs[1]  = '{4'd1,  32'h00000005, 32'h00000005, 32'h00000000, 4'b0100};
    vecs[2]  = '{4'd4,  32'h000000F0, 32'h0000000F, 32'h000000FF, 4'b0000};
    vecs[3]  = '{4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0101};
    vecs[4]  = '{4'd1,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b0011};
    vecs[5]  = '{4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0010};
    vecs[6]  = '{4'd3,  32'h00000001, 32'h00000002, 32'h00000003, 4'b0000};
    vecs[7]  = '{4'd5,  32'h00000001, 32'h0000001F, 32'h80000000, 4'b0010};
    vecs[8]  = '{4'd6,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000};
    vecs[9]  = '{4'd7,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0100};
    vecs[10] = '{4'd8,  32'h80000000, 32'h00000004, 32'h08000000, 4'b0000};
    vecs[11] = '{4'd9,  32'h80000000, 32'h00000004, 32'hF8000000, 4'b0010};
    vecs[12] = '{4'd12, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 4'b0000};

    @(negedge clk);

    // Reset with both requesters valid.
    arstn = 1'b0;
    v = 2'b11;
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_ready", 64'(rdy_o), 64'd0);
      chk("reset_rsp_valid", 64'(rv_o), 64'd0);
      chk("reset_alu_ctrl", 64'(alu_ctl), 64'd0);
      chk("reset_alu_src", {alu_s1, alu_s2}, 64'd0);
    end
    arstn = 1'b1;
    v = 2'b00;
    tick();

    // Table of single transactions, alternating requesters.
    for (int i = 0; i < 13; i++) run_single(i % 2, vecs[i], i);

    // Contention: both requesters valid continuously.
    do_reset(2);
    rr = 2'b11;
    v = 2'b11;
    op[0] = 4'd1; a[0] = 32'd5;    b[0] = 32'd5;
    op[1] = 4'd4; a[1] = 32'hF0;   b[1] = 32'h0F;
    grants.delete();
    for (int i = 0; i < 10; i++) tick();
    v = 2'b00;
    for (int i = 0; i < 2; i++) tick();
    chk("contention_grant_count", 64'(grants.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_g = 0;
`else
      exp_g = k % 2;
`endif
      chk($sformatf("contention_grant_%0d", k),
          64'((k < grants.size()) ? grants[k] : 7), 64'(exp_g));
    end

    // Response backpressure on requester 0 while requester 1 waits.
    v = 2'b01;
    rr = 2'b00;
    op[0] = 4'd0; a[0] = 32'd3; b[0] = 32'd4;
    tick();                        // accept req 0
    v = 2'b10;
    rr = 2'b10;                    // non-owner ready must be ignored
    op[1] = 4'd3; a[1] = 32'd1; b[1] = 32'd2;
    #1;
    chk("bp_exec_ready1", 64'(rdy_o[1]), 64'd0);
    tick();                        // EXEC
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_rsp_valid0", 64'(rv_o[0]), 64'd1);
      chk("bp_result", 64'(rsp_result), 64'd7);
      chk("bp_flags", 64'(rsp_flags), 64'd0);
      chk("bp_ready1", 64'(rdy_o[1]), 64'd0);
      tick();
    end
    rr = 2'b11;
    tick();                        // release
    #1;
    chk("bp_grant_after_release", 64'(rdy_o[1]), 64'd1);
    tick();
    v = 2'b00;
    tick();
    #1;
    chk("bp_req1_rsp_valid", 64'(rv_o[1]), 64'd1);
    chk("bp_req1_result", 64'(rsp_result), 64'd3);
    tick();

    // Reset while an operation is in EXEC.
    v = 2'b01;
    op[0] = 4'd0; a[0] = 32'd1; b[0] = 32'd1;
    tick();                        // accept
    v = 2'b00;
    arstn = 1'b0;
    tick();                        // reset edge during EXEC
    arstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("midreset_rsp_valid", 64'(rv_o), 64'd0);
      chk("midreset_busy", 64'(busy), 64'd0);
      tick();
    end

    // Randomized traffic against the reference model.
    pend = 2'b00;
    for (int i = 0; i < 600; i++) begin
      for (int r = 0; r < 2; r++) begin
        if (!(pend[r] && $urandom_range(7) != 0)) begin
          v[r]  = 1'($urandom_range(1));
          op[r] = 4'($urandom_range(15));
          a[r]  = rand_operand();
          b[r]  = rand_operand();
        end
      end
      rr = 2'($urandom_range(3)) | ($urandom_range(1) != 0 ? 2'b11 : 2'b00);
      tick();
      pend = v & ~last_er;
    end
    v = 2'b00;
    rr = 2'b11;
    for (int i = 0; i < 4; i++) tick();
    chk("final_idle", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
